event_flag_reader: RTL and testbench

//  Clocked consumer for asynchronous set/reset flag flip-flops, e.g. vsync, hsync and bus-write latches.

---
 rtl/event_flag_reader_pkg.sv | 18 +
 rtl/ef_sync.sv | 23 ++
 rtl/event_flag_reader.sv | 132 +++++++++++++
 tb/tb_event_flag_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/event_flag_reader_pkg.sv
// Shared types for the event flag reader: per-channel state encoding and counter sizing.
package event_flag_reader_pkg;

  typedef enum logic [1:0] {
    EF_IDLE = 2'd0,
    EF_PEND = 2'd1,
    EF_CLR  = 2'd2,
    EF_WAIT = 2'd3
  } ef_state_e;

  // One counter per channel times both the clear pulse and the wait window.
  function automatic int ef_cnt_w(input int clr_cycles, input int wait_total);
    int m;
    m = (clr_cycles > wait_total) ? clr_cycles : wait_total;
    return (m > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/ef_sync.sv
// Multi-flop synchroniser for one asynchronous flag level, cleared by the block reset.
module ef_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/event_flag_reader.sv
// Synchronises async flag flops, presents pending events lowest-index first, and clears them on ack.
// Optional sticky overrun reporting is enabled by defining EVENT_FLAG_OVERRUN_EN.
module event_flag_reader
  import event_flag_reader_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES  = 2,
  parameter int WAIT_MAX    = 4,
  localparam int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N_CH-1:0] flag_in,
  output logic [N_CH-1:0] flag_clr,
  input  logic            ack,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_CH-1:0] pending
`ifdef EVENT_FLAG_OVERRUN_EN
  ,
  input  logic            ovr_clr,
  output logic [N_CH-1:0] overrun
`endif
);

  localparam int WAIT_TOTAL = SYNC_STAGES + WAIT_MAX;
  localparam int CNT_W      = ef_cnt_w(CLR_CYCLES, WAIT_TOTAL);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_TOTAL);

  logic [N_CH-1:0] gnt_oh;
  logic            gnt_found;

  // Grant is taken from registered PEND state only, so a new lower-index event waits a cycle.
  always_comb begin
    gnt_oh    = '0;
    evt_id    = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (pending[i] && !gnt_found) begin
        gnt_found = 1'b1;
        gnt_oh[i] = 1'b1;
        evt_id    = ID_W'(i);
      end
    end
  end

  assign evt_valid = |pending;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ef_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fs;
    logic             timeout;

    ef_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .nreset (nreset),
      .d      (flag_in[g]),
      .q      (fs)
    );

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        state_q <= EF_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timeout = 1'b0;
      case (state_q)
        EF_IDLE: if (fs) state_d = EF_PEND;
        EF_PEND: begin
          if (gnt_oh[g] && ack) begin
            state_d = EF_CLR;
            cnt_d   = CLR_LOAD;
          end
        end
        EF_CLR: begin
          if (cnt_q == '0) begin
            state_d = EF_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        EF_WAIT: begin
          // Flag still high when the window closes: a new set beat the clear.
          if (!fs) begin
            state_d = EF_IDLE;
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = EF_PEND;
            timeout = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = EF_IDLE;
      endcase
    end

    assign pending[g]  = (state_q == EF_PEND);
    assign flag_clr[g] = (state_q == EF_CLR);

`ifdef EVENT_FLAG_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        ovr_q <= 1'b0;
      end else if (ovr_clr) begin
        ovr_q <= 1'b0;
      end else if (timeout) begin
        ovr_q <= 1'b1;
      end
    end

    assign overrun[g] = ovr_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout;
`endif
  end

endmodule

// File: tb/tb_event_flag_reader.sv
// Directed bench for event_flag_reader driving set-dominant behavioural flag flops.
module tb_event_flag_reader;

  localparam int N = 4;

  logic         clk;
  logic         nreset;
  logic [N-1:0] set_in;
  logic [N-1:0] flag = '0;
  logic [N-1:0] flag_clr;
  logic         ack;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
`ifdef EVENT_FLAG_OVERRUN_EN
  logic         ovr_clr;
  logic [N-1:0] overrun;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  event_flag_reader dut (
    .clk       (clk),
    .nreset    (nreset),
    .flag_in   (flag),
    .flag_clr  (flag_clr),
    .ack       (ack),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending)
`ifdef EVENT_FLAG_OVERRUN_EN
    ,
    .ovr_clr   (ovr_clr),
    .overrun   (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set-dominant async set/reset flag flop per channel.
  always @(set_in or flag_clr) begin
    for (int i = 0; i < N; i++) begin
      if (set_in[i]) flag[i] = 1'b1;
      else if (flag_clr[i]) flag[i] = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed evt_id %0d expected none queued", tag, evt_id);
    end else begin
      check(tag, {30'd0, evt_id}, exp_q.pop_front());
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, evt_valid}, 32'd1);
  endtask

  task automatic pulse_set(input logic [N-1:0] mask);
    set_in = mask;
    tick();
    set_in = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset = 1'b0;
    set_in = '0;
    ack    = 1'b0;
`ifdef EVENT_FLAG_OVERRUN_EN
    ovr_clr = 1'b0;
`endif
    repeat (3) tick();
    check("rst_flag_clr", {28'd0, flag_clr}, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_id", {30'd0, evt_id}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
`ifdef EVENT_FLAG_OVERRUN_EN
    check("rst_overrun", {28'd0, overrun}, 32'd0);
`endif
    nreset = 1'b1;
    tick();

    // 1: single event on ch2, latency and clear pulse width
    exp_q.push_back(2);
    pulse_set(4'b0100);
    check("t1_lat1", {31'd0, evt_valid}, 32'd0);
    tick();
    check("t1_lat2", {31'd0, evt_valid}, 32'd0);
    tick();
    check("t1_lat3", {31'd0, evt_valid}, 32'd1);
    check_evt("t1_id");
    do_ack();
    check("t1_clr1", {28'd0, flag_clr}, 32'h4);
    check("t1_flag_fell", {28'd0, flag}, 32'd0);
    tick();
    check("t1_clr2", {28'd0, flag_clr}, 32'h4);
    tick();
    check("t1_clr_end", {28'd0, flag_clr}, 32'd0);
    tick();
    check("t1_idle_pend", {28'd0, pending}, 32'd0);
    check("t1_idle_valid", {31'd0, evt_valid}, 32'd0);

    // 2: priority between ch1 and ch3
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse_set(4'b1010);
    wait_valid("t2_valid", 10);
    check_evt("t2_first");
    do_ack();
    check_evt("t2_second");
    check("t2_pend3", {28'd0, pending}, 32'h8);
    do_ack();
    check("t2_pend_none", {28'd0, pending}, 32'd0);
    repeat (6) tick();
    check("t2_flags", {28'd0, flag}, 32'd0);

    // 3: spurious ack with nothing presented
    ack = 1'b1;
    check("t3_clr_now", {28'd0, flag_clr}, 32'd0);
    tick();
    ack = 1'b0;
    check("t3_clr", {28'd0, flag_clr}, 32'd0);
    check("t3_pend", {28'd0, pending}, 32'd0);
    tick();
    check("t3_clr_late", {28'd0, flag_clr}, 32'd0);
    check("t3_valid", {31'd0, evt_valid}, 32'd0);

    // 4: ch0 held set through its clear -> WAIT timeout re-enters PEND
    set_in = 4'b0001;
    exp_q.push_back(0);
    wait_valid("t4_valid", 10);
    check_evt("t4_id");
`ifdef EVENT_FLAG_OVERRUN_EN
    check("t4_ovr_before", {28'd0, overrun}, 32'd0);
`endif
    do_ack();
    check("t4_clr", {28'd0, flag_clr}, 32'h1);
    check("t4_flag_held", {28'd0, flag}, 32'h1);
    tick();
    tick();
    check("t4_wait_clr", {28'd0, flag_clr}, 32'd0);
    check("t4_wait_valid", {31'd0, evt_valid}, 32'd0);
    repeat (5) tick();
    check("t4_wait5", {31'd0, evt_valid}, 32'd0);
    exp_q.push_back(0);
    tick();
    check("t4_repend", {31'd0, evt_valid}, 32'd1);
    check_evt("t4_reid");
`ifdef EVENT_FLAG_OVERRUN_EN
    check("t4_ovr_set", {28'd0, overrun}, 32'h1);
    tick();
    check("t4_ovr_sticky", {28'd0, overrun}, 32'h1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t4_ovr_clr", {28'd0, overrun}, 32'd0);
`endif
    set_in = '0;
    do_ack();
    repeat (6) tick();
    check("t4_done_pend", {28'd0, pending}, 32'd0);
    check("t4_done_flag", {28'd0, flag}, 32'd0);

    // 5: reset asserted while ch1 is clearing; ch3 set during reset is seen afterwards
    exp_q.push_back(1);
    pulse_set(4'b0010);
    wait_valid("t5_valid", 10);
    check_evt("t5_id");
    do_ack();
    check("t5_clr", {28'd0, flag_clr}, 32'h2);
    #2;
    nreset = 1'b0;
    #1;
    check("t5_rst_clr", {28'd0, flag_clr}, 32'd0);
    check("t5_rst_valid", {31'd0, evt_valid}, 32'd0);
    check("t5_rst_pend", {28'd0, pending}, 32'd0);
    check("t5_rst_id", {30'd0, evt_id}, 32'd0);
    set_in = 4'b1000;
    #1;
    set_in = '0;
    tick();
    tick();
    check("t5_in_rst", {28'd0, pending}, 32'd0);
    nreset = 1'b1;
    exp_q.push_back(3);
    wait_valid("t5_redetect", 10);
    check_evt("t5_reid");
    check("t5_pend3", {28'd0, pending}, 32'h8);
    do_ack();
    repeat (6) tick();
    check("t5_done", {28'd0, pending}, 32'd0);

    // 6: back-to-back events on ch0
    exp_q.push_back(0);
    pulse_set(4'b0001);
    wait_valid("t6_valid1", 10);
    check_evt("t6_id1");
    do_ack();
    tick();
    tick();
    tick();
    check("t6_idle", {31'd0, evt_valid}, 32'd0);
    tick();
    exp_q.push_back(0);
    pulse_set(4'b0001);
    wait_valid("t6_valid2", 10);
    check_evt("t6_id2");
    do_ack();
    repeat (6) tick();
    check("t6_done", {28'd0, pending}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
